// File: rtl/sir_arb_if.sv
// Sir arbiter bundle: two requester command ports, shared response and the Sir master bus.
// master is the arbiter side; slave is the side that issues commands and models the bank.
interface sir_arb_if #(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 32
);
  logic                 Req0Vld;
  logic                 Req0Read;
  logic [ADDRWIDTH-1:0] Req0Addr;
  logic [DATAWIDTH-1:0] Req0Wdat;
  logic                 Req0Rdy;
  logic                 Req0Done;
  logic                 Req1Vld;
  logic                 Req1Read;
  logic [ADDRWIDTH-1:0] Req1Addr;
  logic [DATAWIDTH-1:0] Req1Wdat;
  logic                 Req1Rdy;
  logic                 Req1Done;
  logic [DATAWIDTH-1:0] RspRdat;
  logic                 RspErr;
  logic                 SirSel;
  logic                 SirRead;
  logic [ADDRWIDTH-1:0] SirAddr;
  logic [DATAWIDTH-1:0] SirWdat;
  logic                 SirDack;
  logic [DATAWIDTH-1:0] SirRdat;

  modport master (
    input  Req0Vld, Req0Read, Req0Addr, Req0Wdat,
    input  Req1Vld, Req1Read, Req1Addr, Req1Wdat,
    output Req0Rdy, Req0Done, Req1Rdy, Req1Done,
    output RspRdat, RspErr,
    output SirSel, SirRead, SirAddr, SirWdat,
    input  SirDack, SirRdat
  );

  modport slave (
    output Req0Vld, Req0Read, Req0Addr, Req0Wdat,
    output Req1Vld, Req1Read, Req1Addr, Req1Wdat,
    input  Req0Rdy, Req0Done, Req1Rdy, Req1Done,
    input  RspRdat, RspErr,
    input  SirSel, SirRead, SirAddr, SirWdat,
    output SirDack, SirRdat
  );
endinterface

// File: rtl/sir_arb.sv
// Two-requester round-robin arbiter and Sir bus master: one access at a time,
// ack or timeout completion, then a forced SirSel-low gap so slave ack edges re-arm.
module sir_arb #(
  parameter int ADDRWIDTH  = 8,
  parameter int DATAWIDTH  = 32,
  parameter int TIMEOUT    = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst,
  sir_arb_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  logic [1:0]                 vld, rd, gnt, rdy, done;
  logic [1:0][ADDRWIDTH-1:0]  addr;
  logic [1:0][DATAWIDTH-1:0]  wdat;
  logic                       gsel, ptr, owner;
  logic [1:0]                 state;
  logic [TW-1:0]              tcnt;
  logic [GW-1:0]              gcnt;
  logic                       sel, sir_read, rsp_err;
  logic [ADDRWIDTH-1:0]       sir_addr;
  logic [DATAWIDTH-1:0]       sir_wdat, rsp_rdat;

  assign vld  = {bus.Req1Vld,  bus.Req0Vld};
  assign rd   = {bus.Req1Read, bus.Req0Read};
  assign addr = {bus.Req1Addr, bus.Req0Addr};
  assign wdat = {bus.Req1Wdat, bus.Req0Wdat};

  // ptr names the requester that wins when both are valid
  always_comb begin
    gnt = vld;
    if (&vld) gnt = ptr ? 2'b10 : 2'b01;
  end

  assign gsel = gnt[1];
  assign rdy  = (state == IDLE) ? gnt : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      tcnt     <= '0;
      gcnt     <= '0;
      sel      <= 1'b0;
      sir_read <= 1'b0;
      sir_addr <= '0;
      sir_wdat <= '0;
      done     <= 2'b00;
      rsp_rdat <= '0;
      rsp_err  <= 1'b0;
    end else begin
      done     <= 2'b00;
      rsp_rdat <= '0;
      rsp_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (|rdy) begin
            sel      <= 1'b1;
            sir_read <= rd[gsel];
            sir_addr <= addr[gsel];
            sir_wdat <= wdat[gsel];
            owner    <= gsel;
            ptr      <= ~gsel;
            tcnt     <= TW'(1);
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // an ack landing on the timeout cycle still completes cleanly
          if (bus.SirDack || tcnt == TMAX) begin
            sel         <= 1'b0;
            sir_read    <= 1'b0;
            sir_addr    <= '0;
            sir_wdat    <= '0;
            done[owner] <= 1'b1;
            rsp_err     <= ~bus.SirDack;
            rsp_rdat    <= (bus.SirDack && sir_read) ? bus.SirRdat : '0;
            gcnt        <= GW'(1);
            state       <= GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GAP: begin
          if (gcnt == GMAX) begin
            gcnt  <= '0;
            state <= IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Req0Rdy  = rdy[0];
  assign bus.Req1Rdy  = rdy[1];
  assign bus.Req0Done = done[0];
  assign bus.Req1Done = done[1];
  assign bus.RspRdat  = rsp_rdat;
  assign bus.RspErr   = rsp_err;
  assign bus.SirSel   = sel;
  assign bus.SirRead  = sir_read;
  assign bus.SirAddr  = sir_addr;
  assign bus.SirWdat  = sir_wdat;
endmodule
